// File: rtl/bsc_scan_sequencer.sv
// Boundary-scan chain sequencer: runs one capture / shift / update pass over an
// external chain and returns the word shifted out of it.
module bsc_scan_sequencer #(
    parameter int CHAIN_LENGTH = 8
) (
    input  logic                    tck,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    capture_en,
    input  logic                    update_en,
    input  logic                    test_mode,
    input  logic                    abort,
    input  logic [CHAIN_LENGTH-1:0] pattern_in,
    input  logic                    bsc_tdo,
    output logic                    bsc_tdi,
    output logic [3:0]              bsc_control,
    output logic                    busy,
    output logic                    done,
    output logic [CHAIN_LENGTH-1:0] result_out
);

    localparam int CW = $clog2(CHAIN_LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CHAIN_LENGTH-1:0] pat_q, pat_d;
    logic [CHAIN_LENGTH-1:0] res_q, res_d;
    logic [CHAIN_LENGTH-1:0] result_q, result_d;
    logic                    upd_q, upd_d;
    logic                    tm_q, tm_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        res_d    = res_q;
        result_d = result_q;
        upd_d    = upd_q;
        tm_d     = tm_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern_in;
                    upd_d   = update_en;
                    tm_d    = test_mode;
                    cnt_d   = '0;
                    state_d = capture_en ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: state_d = SHIFT;
            SHIFT: begin
                // First sampled bit walks down to bit 0 after CHAIN_LENGTH shifts.
                pat_d = pat_q >> 1;
                res_d = {bsc_tdo, res_q[CHAIN_LENGTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (upd_q) begin
                        state_d = UPDATE;
                    end else begin
                        state_d  = DONE;
                        result_d = res_d;
                    end
                end
            end
            UPDATE: begin
                state_d  = DONE;
                result_d = res_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q == CAPTURE || state_q == SHIFT || state_q == UPDATE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            upd_q    <= 1'b0;
            tm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            res_q    <= res_d;
            result_q <= result_d;
            upd_q    <= upd_d;
            tm_q     <= tm_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign bsc_control[0] = (state_q == SHIFT);
    assign bsc_control[1] = (state_q == CAPTURE);
    assign bsc_control[2] = (state_q == UPDATE);
    assign bsc_control[3] = busy & tm_q;
    assign bsc_tdi        = (state_q == SHIFT) & pat_q[0];
    assign result_out     = result_q;

endmodule

// File: tb/tb_bsc_scan_sequencer.sv
// Directed bench for bsc_scan_sequencer: per-cycle checks of control, serial data,
// done timing and result word against hand-derived expectations.
module tb_bsc_scan_sequencer;

    localparam int N = 8;

    logic         tck = 1'b0;
    logic         reset, start, capture_en, update_en, test_mode, abort, bsc_tdo;
    logic [N-1:0] pattern_in;
    logic         bsc_tdi, busy, done;
    logic [3:0]   bsc_control;
    logic [N-1:0] result_out;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [N-1:0] prev_res = '0;

    bsc_scan_sequencer #(.CHAIN_LENGTH(N)) dut (
        .tck(tck), .reset(reset), .start(start), .capture_en(capture_en),
        .update_en(update_en), .test_mode(test_mode), .abort(abort),
        .pattern_in(pattern_in), .bsc_tdo(bsc_tdo), .bsc_tdi(bsc_tdi),
        .bsc_control(bsc_control), .busy(busy), .done(done), .result_out(result_out)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input logic [N-1:0] res);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " ctl"},  32'(bsc_control), 32'd0);
        chk({tag, " tdi"},  32'(bsc_tdi), 32'd0);
        chk({tag, " res"},  32'(result_out), 32'(res));
    endtask

    // One operation; abort_at / rst_at name the cycle (1 = first after the start
    // edge) during which abort / reset is raised, 0 = never.
    task automatic run_op(input string tag, input logic [N-1:0] pat, input logic [N-1:0] ret,
                          input logic cap, input logic upd, input logic tm,
                          input logic extra, input int abort_at, input int rst_at);
        int lat;
        int i;
        int dones;
        logic inshift;
        logic [3:0] ectl;
        lat   = 1 + int'(cap) + N + int'(upd);
        dones = 0;
        pattern_in = pat; capture_en = cap; update_en = upd; test_mode = tm; start = 1'b1;
        @(posedge tck); #1;
        // Flip the operands to prove they were latched at the start edge.
        start = extra; pattern_in = ~pat; capture_en = ~cap; update_en = ~upd; test_mode = ~tm;
        for (int c = 1; c <= lat; c++) begin
            i       = c - 1 - int'(cap);
            inshift = (i >= 0) && (i < N);
            ectl    = {tm, upd && (c == int'(cap) + N + 1), cap && (c == 1), inshift};
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " ctl"},  32'(bsc_control), 32'(ectl));
            chk({tag, " tdi"},  32'(bsc_tdi), inshift ? 32'(pat[i]) : 32'd0);
            chk({tag, " done"}, 32'(done), 32'(c == lat));
            chk({tag, " res"},  32'(result_out), (c == lat) ? 32'(ret) : 32'(prev_res));
            if (done) dones++;
            bsc_tdo = inshift ? ret[i] : 1'b0;
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) reset = 1'b1;
            @(posedge tck); #1;
            abort = 1'b0; reset = 1'b0; bsc_tdo = 1'b0;
            if (c == abort_at) begin
                start = 1'b0;
                idle_chk({tag, " post-abort"}, prev_res);
                return;
            end
            if (c == rst_at) begin
                start = 1'b0;
                prev_res = '0;
                idle_chk({tag, " post-reset"}, '0);
                return;
            end
        end
        start = 1'b0;
        prev_res = ret;
        chk({tag, " done count"}, 32'(dones), 32'd1);
        idle_chk({tag, " end"}, ret);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b1; capture_en = 1'b1; update_en = 1'b1;
        test_mode = 1'b1; bsc_tdo = 1'b1; pattern_in = 8'hFF;
        repeat (2) @(posedge tck);
        #1;
        idle_chk("reset", '0);
        start = 1'b0; bsc_tdo = 1'b0; reset = 1'b0;
        // Abort while idle does nothing.
        @(posedge tck); #1;
        abort = 1'b0;
        idle_chk("idle abort", '0);

        run_op("full",    8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        run_op("skip",    8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        run_op("b2b",     8'h0F, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        run_op("abort",   8'h96, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 6, 0);
        run_op("rstupd",  8'h5A, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 0, 9);
        run_op("recover", 8'h33, 8'hE7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
